// File: rtl/uart_rx_fifo.sv
// 16x oversampling UART receiver (8N1) feeding a first-word-fall-through FIFO.
// RTS is driven from FIFO occupancy so the sender pauses before overflow.
`timescale 1ns/1ps
module uart_rx_fifo #(
   parameter int BaudRate             = 9600,
   parameter int SystemClockFrequency = 156250000,
   parameter int FifoDepth            = 8,
   parameter int RtsThreshold         = 6
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_uart_rx,
   output logic                           o_uart_rts_n,
   output logic [7:0]                     o_rx_data,
   output logic                           o_rx_valid,
   input  logic                           i_rx_ready,
   output logic [$clog2(FifoDepth):0]     o_fifo_count,
   output logic                           o_is_receiving,
   output logic                           o_frame_err,
   output logic                           o_overrun_err,
   input  logic                           i_clr_err
);

   localparam int ClksPerSample = SystemClockFrequency / (BaudRate * 16);
   localparam int CW            = (ClksPerSample > 1) ? $clog2(ClksPerSample) : 1;
   localparam int AW            = $clog2(FifoDepth);
   localparam int NW            = AW + 1;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   // Synchronizer and the previous synchronized value for falling-edge detection.
   logic [1:0] sync;
   logic       rx_s;
   logic       rx_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync    <= 2'b11;
         rx_prev <= 1'b1;
      end else begin
         sync    <= {sync[0], i_uart_rx};
         rx_prev <= sync[1];
      end
   end

   assign rx_s = sync[1];

   state_t     state;
   logic [CW-1:0] cnt;
   logic       tick;
   logic       start_edge;

   assign tick       = (cnt == CW'(ClksPerSample - 1));
   assign start_edge = rx_prev & ~rx_s;

   // Sample-rate divider; realigned to the start edge so ticks land mid-bit.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                          cnt <= '0;
      else if (state == IDLE && start_edge)  cnt <= '0;
      else if (tick)                         cnt <= '0;
      else                                   cnt <= cnt + CW'(1);
   end

   logic [3:0] tick_idx;
   logic [3:0] hi_cnt;
   logic [2:0] bit_idx;
   logic [7:0] shreg;
   logic       s7, s8;
   logic       maj;
   logic       mid_tick;
   logic       push;
   logic       frame_set;

   assign maj      = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
   assign mid_tick = tick && (tick_idx == 4'd9);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state          <= IDLE;
         tick_idx       <= '0;
         hi_cnt         <= '0;
         bit_idx        <= '0;
         shreg          <= '0;
         s7             <= 1'b1;
         s8             <= 1'b1;
         push           <= 1'b0;
         frame_set      <= 1'b0;
         o_is_receiving <= 1'b0;
      end else begin
         push      <= 1'b0;
         frame_set <= 1'b0;
         if (tick) begin
            tick_idx <= tick_idx + 4'd1;
            if (tick_idx == 4'd7) s7 <= rx_s;
            if (tick_idx == 4'd8) s8 <= rx_s;
         end
         case (state)
            IDLE: begin
               if (start_edge) begin
                  state          <= START;
                  tick_idx       <= '0;
                  o_is_receiving <= 1'b1;
               end
            end
            START: begin
               if (mid_tick) begin
                  if (!maj) begin
                     state   <= DATA;
                     bit_idx <= '0;
                  end else begin
                     state          <= IDLE;
                     o_is_receiving <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (mid_tick) begin
                  shreg   <= {maj, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= STOP;
               end
            end
            STOP: begin
               if (mid_tick) begin
                  if (maj) begin
                     push           <= 1'b1;
                     state          <= IDLE;
                     o_is_receiving <= 1'b0;
                  end else begin
                     frame_set <= 1'b1;
                     hi_cnt    <= '0;
                     state     <= WAIT_IDLE;
                  end
               end
            end
            WAIT_IDLE: begin
               // A held break keeps us here; need 16 consecutive high samples.
               if (tick) begin
                  if (rx_s) begin
                     hi_cnt <= hi_cnt + 4'd1;
                     if (hi_cnt == 4'd15) begin
                        state          <= IDLE;
                        o_is_receiving <= 1'b0;
                     end
                  end else begin
                     hi_cnt <= '0;
                  end
               end
            end
            default: begin
               state          <= IDLE;
               o_is_receiving <= 1'b0;
            end
         endcase
      end
   end

   logic [7:0]    mem [FifoDepth];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [NW-1:0] count_nx;
   logic          full, do_wr, do_rd, overrun_set;

   assign full        = (o_fifo_count == NW'(FifoDepth));
   assign do_rd       = o_rx_valid && i_rx_ready;
   assign do_wr       = push && (!full || do_rd);
   assign overrun_set = push && full && !do_rd;
   assign o_rx_data   = mem[rd_ptr];

   always_comb begin
      count_nx = o_fifo_count;
      if (do_wr && !do_rd)      count_nx = o_fifo_count + NW'(1);
      else if (!do_wr && do_rd) count_nx = o_fifo_count - NW'(1);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < FifoDepth; i++) mem[i] <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         o_fifo_count <= '0;
         o_rx_valid   <= 1'b0;
         o_uart_rts_n <= 1'b1;
      end else begin
         if (do_wr) begin
            mem[wr_ptr] <= shreg;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         o_fifo_count <= count_nx;
         o_rx_valid   <= (count_nx != '0);
         o_uart_rts_n <= (o_fifo_count >= NW'(RtsThreshold));
      end
   end

   // Sticky flags: a set in the same cycle as a clear takes priority.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_frame_err   <= 1'b0;
         o_overrun_err <= 1'b0;
      end else begin
         if (frame_set)      o_frame_err <= 1'b1;
         else if (i_clr_err) o_frame_err <= 1'b0;
         if (overrun_set)    o_overrun_err <= 1'b1;
         else if (i_clr_err) o_overrun_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: 10 clk/sample, 160 clk/bit.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic       i_uart_rx;
   logic       o_uart_rts_n;
   logic [7:0] o_rx_data;
   logic       o_rx_valid;
   logic       i_rx_ready;
   logic [3:0] o_fifo_count;
   logic       o_is_receiving;
   logic       o_frame_err;
   logic       o_overrun_err;
   logic       i_clr_err;

   int vectors = 0;
   int fails   = 0;
   logic [7:0] popq[$];

   uart_rx_fifo #(
      .BaudRate(10000), .SystemClockFrequency(1600000),
      .FifoDepth(8), .RtsThreshold(6)
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_uart_rx(i_uart_rx),
      .o_uart_rts_n(o_uart_rts_n), .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
      .i_rx_ready(i_rx_ready), .o_fifo_count(o_fifo_count),
      .o_is_receiving(o_is_receiving), .o_frame_err(o_frame_err),
      .o_overrun_err(o_overrun_err), .i_clr_err(i_clr_err)
   );

   always #5 i_clk = ~i_clk;

   // Record every byte the consumer takes (pop happens at the following posedge).
   always @(negedge i_clk)
      if (i_rst_n && o_rx_valid && i_rx_ready) popq.push_back(o_rx_data);

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      assert (act === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic send_bit(input logic v, input int n);
      i_uart_rx = v;
      step(n);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      send_bit(1'b0, 160);
      for (int i = 0; i < 8; i++) send_bit(b[i], 160);
      send_bit(stop_bit, 160);
   endtask

   // Inverts one data bit for 10 clk around its tick-8 sample only.
   task automatic send_frame_glitch(input logic [7:0] b, input int gbit);
      send_bit(1'b0, 160);
      for (int i = 0; i < 8; i++) begin
         if (i == gbit) begin
            send_bit(b[i], 85);
            send_bit(~b[i], 10);
            send_bit(b[i], 65);
         end else begin
            send_bit(b[i], 160);
         end
      end
      send_bit(1'b1, 160);
   endtask

   logic [31:0] head;
   logic        found;

   initial begin
      i_rst_n = 1'b0; i_uart_rx = 1'b1; i_rx_ready = 1'b0; i_clr_err = 1'b0;
      step(5);
      check("rst_rts_n",   o_uart_rts_n,   1);
      check("rst_valid",   o_rx_valid,     0);
      check("rst_count",   o_fifo_count,   0);
      check("rst_data",    o_rx_data,      0);
      check("rst_recv",    o_is_receiving, 0);
      check("rst_ferr",    o_frame_err,    0);
      check("rst_oerr",    o_overrun_err,  0);
      i_rst_n = 1'b1;
      step(1);
      check("rel_rts_n", o_uart_rts_n, 0);
      step(20);

      // Single frame, consumer always ready
      i_rx_ready = 1'b1;
      popq.delete();
      fork
         send_frame(8'hA5, 1'b1);
         begin
            step(800);
            check("t1_busy", o_is_receiving, 1);
         end
      join
      head = (popq.size() > 0) ? 32'(popq[0]) : 32'hDEAD;
      check("t1_pops", popq.size(), 1);
      check("t1_data", head, 32'hA5);
      check("t1_recv", o_is_receiving, 0);
      check("t1_ferr", o_frame_err, 0);
      check("t1_oerr", o_overrun_err, 0);
      check("t1_count", o_fifo_count, 0);

      // Burst 0x01..0x08, consumer stalled
      i_rx_ready = 1'b0;
      popq.delete();
      for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
      check("t2_rts_at5", o_uart_rts_n, 0);
      found = 1'b0;
      fork
         send_frame(8'h06, 1'b1);
         begin
            for (int k = 0; k < 2000; k++) begin
               step(1);
               if (o_fifo_count == 4'd6) begin
                  found = 1'b1;
                  break;
               end
            end
            check("t2_found6", found, 1);
            check("t2_rts_same_cycle", o_uart_rts_n, 0);
            step(1);
            check("t2_rts_next_cycle", o_uart_rts_n, 1);
         end
      join
      send_frame(8'h07, 1'b1);
      send_frame(8'h08, 1'b1);
      step(5);
      check("t2_count8", o_fifo_count, 8);
      check("t2_rts", o_uart_rts_n, 1);
      check("t2_head", o_rx_data, 8'h01);

      // Overrun while full
      send_frame(8'h99, 1'b1);
      check("t3_oerr", o_overrun_err, 1);
      check("t3_count", o_fifo_count, 8);
      check("t3_ferr", o_frame_err, 0);
      i_rx_ready = 1'b1;
      step(3);
      check("t3_count5", o_fifo_count, 5);
      check("t3_rts_lag", o_uart_rts_n, 1);
      step(1);
      check("t3_rts_drop", o_uart_rts_n, 0);
      step(4);
      check("t3_count0", o_fifo_count, 0);
      check("t3_valid0", o_rx_valid, 0);
      check("t3_pops", popq.size(), 8);
      for (int i = 0; i < 8; i++) begin
         head = (popq.size() > i) ? 32'(popq[i]) : 32'hDEAD;
         check($sformatf("t3_drain%0d", i), head, 32'(i + 1));
      end
      i_clr_err = 1'b1;
      step(1);
      i_clr_err = 1'b0;
      check("t3_oerr_clr", o_overrun_err, 0);

      // Glitch on idle, then a one-sample glitch inside a data bit
      popq.delete();
      i_uart_rx = 1'b0;
      step(20);
      i_uart_rx = 1'b1;
      step(40);
      check("t4_in_start", o_is_receiving, 1);
      step(200);
      check("t4_recv", o_is_receiving, 0);
      check("t4_count", o_fifo_count, 0);
      check("t4_ferr", o_frame_err, 0);
      check("t4_pops", popq.size(), 0);
      send_frame_glitch(8'h6B, 4);
      step(5);
      head = (popq.size() > 0) ? 32'(popq[0]) : 32'hDEAD;
      check("t4_glitch_pops", popq.size(), 1);
      check("t4_glitch_data", head, 32'h6B);

      // Framing error followed by a long break
      popq.delete();
      send_frame(8'h3C, 1'b0);
      send_bit(1'b0, 40 * 160);
      check("t5_ferr", o_frame_err, 1);
      check("t5_wait_idle", o_is_receiving, 1);
      check("t5_pops", popq.size(), 0);
      check("t5_count", o_fifo_count, 0);
      i_uart_rx = 1'b1;
      step(200);
      check("t5_idle", o_is_receiving, 0);
      send_frame(8'h55, 1'b1);
      step(5);
      head = (popq.size() > 0) ? 32'(popq[0]) : 32'hDEAD;
      check("t5_next_pops", popq.size(), 1);
      check("t5_next_data", head, 32'h55);
      check("t5_ferr_sticky", o_frame_err, 1);

      // Reset during bit 4 of 0xF0
      i_rx_ready = 1'b0;
      send_bit(1'b0, 160);
      for (int i = 0; i < 4; i++) send_bit(1'(8'hF0 >> i), 160);
      send_bit(1'b1, 80);
      check("t6_busy", o_is_receiving, 1);
      i_rst_n = 1'b0;
      #1;
      check("t6_rts_n", o_uart_rts_n,   1);
      check("t6_valid", o_rx_valid,     0);
      check("t6_count", o_fifo_count,   0);
      check("t6_data",  o_rx_data,      0);
      check("t6_recv",  o_is_receiving, 0);
      check("t6_ferr",  o_frame_err,    0);
      check("t6_oerr",  o_overrun_err,  0);
      i_uart_rx = 1'b1;
      step(5);
      i_rst_n = 1'b1;
      step(20);
      send_frame(8'h0F, 1'b1);
      step(5);
      check("t6_after_count", o_fifo_count, 1);
      check("t6_after_valid", o_rx_valid, 1);
      check("t6_after_data",  o_rx_data, 8'h0F);
      check("t6_after_ferr",  o_frame_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
